// File: rtl/rect_fill_writer_if.sv
// Bus bundle for rect_fill_writer: command stream, frame-memory write port,
// flasher continuation handshake and status.
//   master : command/handshake producer (drives cmd_*, in_cont_signal,
//            next_fin_signal; observes everything else)
//   slave  : rect_fill_writer itself
interface rect_fill_writer_if #(
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int ADDR_BITS  = 15,
  parameter int COLOR_SIZE = 3
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [X_BITS-1:0]     cmd_x;
  logic [Y_BITS-1:0]     cmd_y;
  logic [X_BITS-1:0]     cmd_w;
  logic [Y_BITS-1:0]     cmd_h;
  logic [COLOR_SIZE-1:0] cmd_colour;
  logic                  wr_en;
  logic [ADDR_BITS-1:0]  wr_addr;
  logic [COLOR_SIZE-1:0] wr_data;
  logic                  in_cont_signal;
  logic                  out_cont_signal;
  logic                  next_fin_signal;
  logic                  busy;
  logic                  cmd_err;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
           in_cont_signal, next_fin_signal,
    input  cmd_ready, wr_en, wr_addr, wr_data, out_cont_signal, busy, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
           in_cont_signal, next_fin_signal,
    output cmd_ready, wr_en, wr_addr, wr_data, out_cont_signal, busy, cmd_err
  );
endinterface

// File: rtl/rect_fill_writer.sv
// rect_fill_writer: queues rectangle-fill commands in a small FIFO and
// rasterises each one into the 160x120 frame memory, one pixel per cycle,
// then hands the memory to the screen flasher on request.
//
// Ports
//   Clck   : system clock, rising edge
//   Reset  : asynchronous active-low reset
//   bus    : rect_fill_writer_if.slave
//            cmd_valid/cmd_ready + cmd_x/y/w/h/colour  command push
//            wr_en/wr_addr/wr_data                      frame memory write
//            in_cont_signal/out_cont_signal/next_fin_signal  flasher handoff
//            busy, cmd_err                              status
//
// Build option
//   CLIP_EN : when defined, rectangles are clipped to the screen instead of
//             being rejected; cmd_err is then never asserted.
module rect_fill_writer #(
  parameter int SCR_W      = 160,
  parameter int SCR_H      = 120,
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int ADDR_BITS  = 15,
  parameter int COLOR_SIZE = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic              Clck,
  input logic              Reset,
  rect_fill_writer_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [X_BITS:0]    SCR_W_X  = SCR_W[X_BITS:0];
  localparam logic [Y_BITS:0]    SCR_H_Y  = SCR_H[Y_BITS:0];
  localparam logic [X_BITS:0]    X_ONE    = 1;
  localparam logic [Y_BITS:0]    Y_ONE    = 1;
  localparam logic [ADDR_BITS-1:0] ROW_STEP = SCR_W[ADDR_BITS-1:0];
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, HANDOFF} state_t;

  typedef struct packed {
    logic [X_BITS-1:0]     x;
    logic [Y_BITS-1:0]     y;
    logic [X_BITS-1:0]     w;
    logic [Y_BITS-1:0]     h;
    logic [COLOR_SIZE-1:0] col;
  } cmd_t;

`ifndef CLIP_EN
  // A non-empty rectangle that does not fit on screen is rejected whole.
  function automatic logic range_fail(input logic [X_BITS-1:0] x,
                                      input logic [X_BITS-1:0] w,
                                      input logic [Y_BITS-1:0] y,
                                      input logic [Y_BITS-1:0] h);
    logic [X_BITS:0] x_end;
    logic [Y_BITS:0] y_end;
    x_end = {1'b0, x} + {1'b0, w};
    y_end = {1'b0, y} + {1'b0, h};
    return (w != '0) && (h != '0) && ((x_end > SCR_W_X) || (y_end > SCR_H_Y));
  endfunction
`endif

  state_t                state;
  cmd_t                  fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr, rd_ptr;
  logic                  full, empty, push, pop;
  cmd_t                  head, cur;
  logic                  pop_reject;

  logic                  wr_en_r, out_cont_r, cmd_err_r;
  logic [ADDR_BITS-1:0]  wr_addr_r, row_base;
  logic [COLOR_SIZE-1:0] wr_data_r;
  logic [X_BITS:0]       cur_x;
  logic [Y_BITS:0]       cur_y;

  logic [X_BITS:0]       x_ext, w_ext, w_eff, x_last;
  logic [Y_BITS:0]       y_ext, h_ext, h_eff, y_last;
  logic                  zero_area, reject;
  logic [ADDR_BITS-1:0]  x_addr, y_addr, row_base_ld;

  // Command FIFO: the extra pointer bit separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push  = bus.cmd_valid && !full;
  assign pop   = (state == IDLE) && !empty;
  assign head  = fifo_mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge Clck) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= '{x: bus.cmd_x, y: bus.cmd_y, w: bus.cmd_w,
                                       h: bus.cmd_h, col: bus.cmd_colour};
    end
  end

  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Current command is captured on pop and stays stable through LOAD/DRAW.
  always_ff @(posedge Clck) begin
    if (pop) cur <= head;
  end

`ifdef CLIP_EN
  assign pop_reject = 1'b0;
`else
  // Evaluated on the head entry so the registered pulse lands in LOAD.
  assign pop_reject = range_fail(head.x, head.w, head.y, head.h);
`endif

  always_comb begin
    x_ext  = {1'b0, cur.x};
    y_ext  = {1'b0, cur.y};
    w_ext  = {1'b0, cur.w};
    h_ext  = {1'b0, cur.h};
    w_eff  = w_ext;
    h_eff  = h_ext;
    reject = 1'b0;
`ifdef CLIP_EN
    if (x_ext >= SCR_W_X)               w_eff = '0;
    else if (w_ext > SCR_W_X - x_ext)   w_eff = SCR_W_X - x_ext;
    if (y_ext >= SCR_H_Y)               h_eff = '0;
    else if (h_ext > SCR_H_Y - y_ext)   h_eff = SCR_H_Y - y_ext;
`else
    reject = range_fail(cur.x, cur.w, cur.y, cur.h);
`endif
    zero_area   = (w_eff == '0) || (h_eff == '0);
    x_last      = x_ext + w_eff - X_ONE;
    y_last      = y_ext + h_eff - Y_ONE;
    x_addr      = {{(ADDR_BITS-X_BITS){1'b0}}, cur.x};
    y_addr      = {{(ADDR_BITS-Y_BITS){1'b0}}, cur.y};
    // y*160 as (y*128)+(y*32); later rows step by SCR_W with an adder.
    row_base_ld = (y_addr << 7) + (y_addr << 5);
  end

  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      out_cont_r <= 1'b0;
      cmd_err_r  <= 1'b0;
      row_base   <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
    end else begin
      cmd_err_r <= 1'b0;
      case (state)
        IDLE: begin
          // Queued work takes priority over handing the frame away.
          if (!empty) begin
            state     <= LOAD;
            cmd_err_r <= pop_reject;
          end else if (bus.in_cont_signal) begin
            state <= HANDOFF;
          end
        end
        LOAD: begin
          if (zero_area || reject) begin
            state <= IDLE;
          end else begin
            state     <= DRAW;
            wr_en_r   <= 1'b1;
            wr_addr_r <= row_base_ld + x_addr;
            wr_data_r <= cur.col;
            row_base  <= row_base_ld;
            cur_x     <= x_ext;
            cur_y     <= y_ext;
          end
        end
        DRAW: begin
          // cur_x/cur_y track the pixel presented on the write port now.
          if (cur_x == x_last) begin
            if (cur_y == y_last) begin
              wr_en_r <= 1'b0;
              state   <= IDLE;
            end else begin
              cur_x     <= x_ext;
              cur_y     <= cur_y + Y_ONE;
              row_base  <= row_base + ROW_STEP;
              wr_addr_r <= row_base + ROW_STEP + x_addr;
            end
          end else begin
            cur_x     <= cur_x + X_ONE;
            wr_addr_r <= wr_addr_r + ADDR_ONE;
          end
        end
        HANDOFF: begin
          if (bus.next_fin_signal) begin
            out_cont_r <= 1'b0;
            state      <= IDLE;
          end else begin
            out_cont_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready       = !full;
  assign bus.wr_en           = wr_en_r;
  assign bus.wr_addr         = wr_addr_r;
  assign bus.wr_data         = wr_data_r;
  assign bus.out_cont_signal = out_cont_r;
  assign bus.cmd_err         = cmd_err_r;
  assign bus.busy            = (state != IDLE) || !empty;

endmodule
